// File: rtl/sum4_arbiter.sv
// Round-robin scheduler for two clients sharing one W-bit adder that
// accumulates four latched operands over four cycles.
module sum4_arbiter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_a,
  input  logic [4*W-1:0] ops_a,
  input  logic           req_b,
  input  logic [4*W-1:0] ops_b,
  output logic           gnt_a,
  output logic           gnt_b,
  output logic           done_a,
  output logic           done_b,
  output logic [W-1:0]   sum,
  output logic           ovf,
  output logic           busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACC = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [4*W-1:0] ops_q, ops_d;
  logic           c_q, c_d;
  logic           ovf_q, ovf_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic           gnt_a_q, gnt_a_d;
  logic           gnt_b_q, gnt_b_d;
  logic           done_a_q, done_a_d;
  logic           done_b_q, done_b_d;
  logic           any_req_s;
  logic           win_b_s;
  logic [W:0]     add_s;

  function automatic logic [W-1:0] op_sel(input logic [4*W-1:0] ops, input logic [1:0] i);
    case (i)
      2'd0:    op_sel = ops[W-1:0];
      2'd1:    op_sel = ops[2*W-1:W];
      2'd2:    op_sel = ops[3*W-1:2*W];
      2'd3:    op_sel = ops[4*W-1:3*W];
      default: op_sel = {W{1'b0}};
    endcase
  endfunction

  // Owner and last_winner use 1 for B; B wins a tie only if A won last.
  assign any_req_s = req_a | req_b;
  assign win_b_s   = req_b & (~req_a | ~last_q);

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      acc_q    <= {W{1'b0}};
      sum_q    <= {W{1'b0}};
      ops_q    <= {(4*W){1'b0}};
      c_q      <= 1'b0;
      ovf_q    <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      ops_q    <= ops_d;
      c_q      <= c_d;
      ovf_q    <= ovf_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) state_d = S_ACC;
        else           state_d = S_IDLE;
      end
      S_ACC: begin
        if (idx_q == 2'd3) state_d = S_IDLE;
        else               state_d = S_ACC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latching, accumulation and completion outputs.
  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    ops_d    = ops_q;
    c_d      = c_q;
    ovf_d    = ovf_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    add_s    = {1'b0, acc_q} + {1'b0, op_sel(ops_q, idx_q)};
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          ops_d   = win_b_s ? ops_b : ops_a;
          owner_d = win_b_s;
          last_d  = win_b_s;
          gnt_a_d = ~win_b_s;
          gnt_b_d = win_b_s;
          acc_d   = {W{1'b0}};
          c_d     = 1'b0;
          idx_d   = 2'd0;
        end else begin
          idx_d   = idx_q;
        end
      end
      S_ACC: begin
        acc_d = add_s[W-1:0];
        c_d   = c_q | add_s[W];
        idx_d = idx_q + 2'd1;
        // The last add publishes its result directly, carry included.
        if (idx_q == 2'd3) begin
          sum_d    = add_s[W-1:0];
          ovf_d    = c_q | add_s[W];
          done_a_d = ~owner_q;
          done_b_d = owner_q;
        end else begin
          sum_d    = sum_q;
        end
      end
      default: begin
        idx_d = 2'd0;
      end
    endcase
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign done_a = done_a_q;
  assign done_b = done_b_q;
  assign sum    = sum_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_ACC);

endmodule
